// File: rtl/gray_bin_conv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gray_bin_conv_pipe
// Description : Two-stage valid/ready Gray<->binary converter with a per-word
//               mode bit. Optional Gray-step checker: GBC_STEP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_bin_conv_pipe #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode
`ifdef GBC_STEP_CHECK_EN
   ,
   output logic             out_step_err
`endif
);

   logic             w_adv;
   logic             w_in_fire;
   logic [WIDTH-1:0] w_conv;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_data;
   logic             r_s1_mode;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_mode;

   // Gray to binary is a running XOR from the MSB downwards.
   function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign w_adv     = !r_out_valid || out_ready;
   assign w_in_fire = in_valid && w_adv;
   assign w_conv    = r_s1_mode ? f_bin2gray(r_s1_data) : f_gray2bin(r_s1_data);

   assign in_ready  = w_adv;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_mode  = r_out_mode;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_mode   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_mode  <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid  <= in_valid;
         r_s1_data   <= in_data;
         r_s1_mode   <= in_mode;
         r_out_valid <= r_s1_valid;
         r_out_data  <= w_conv;
         r_out_mode  <= r_s1_mode;
      end
   end

`ifdef GBC_STEP_CHECK_EN
   logic             w_step_err;
   logic             r_hist_valid;
   logic [WIDTH-1:0] r_hist_data;
   logic             r_s1_err;
   logic             r_out_err;

   // Exactly one bit must change between successive Gray words; a repeat is an error.
   assign w_step_err   = r_hist_valid && ($countones(in_data ^ r_hist_data) != 1);
   assign out_step_err = r_out_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hist_valid <= 1'b0;
         r_hist_data  <= '0;
         r_s1_err     <= 1'b0;
         r_out_err    <= 1'b0;
      end else begin
         if (w_adv) begin
            r_s1_err  <= !in_mode && w_step_err;
            r_out_err <= r_s1_err;
         end
         if (w_in_fire && !in_mode) begin
            r_hist_valid <= 1'b1;
            r_hist_data  <= in_data;
         end
      end
   end
`else
   logic w_unused_fire;
   assign w_unused_fire = w_in_fire;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_bin_conv_pipe.sv
`default_nettype none
// Scoreboard bench for gray_bin_conv_pipe: randomized and directed traffic
// against an arithmetic reference model; WIDTH=4 main instance plus a WIDTH=8 instance.
module tb_gray_bin_conv_pipe;
   localparam int W = 4;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready, in_mode = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         out_valid, out_ready = 1'b1, out_mode;
   logic [W-1:0] out_data;

   logic         in_valid8 = 1'b0, in_ready8, in_mode8 = 1'b0;
   logic [7:0]   in_data8 = '0;
   logic         out_valid8, out_ready8 = 1'b1, out_mode8;
   logic [7:0]   out_data8;
`ifdef GBC_STEP_CHECK_EN
   logic         out_step_err, out_step_err8;
`endif

   gray_bin_conv_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef GBC_STEP_CHECK_EN
      , .out_step_err(out_step_err)
`endif
   );

   gray_bin_conv_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_mode(out_mode8)
`ifdef GBC_STEP_CHECK_EN
      , .out_step_err(out_step_err8)
`endif
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         m;
      logic         e;
   } exp_t;

   exp_t         q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic         m_hist_v = 1'b0;
   logic [W-1:0] m_hist_d = '0;

   // Gray->binary as XOR of all right shifts of the code word.
   function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_expected(input logic [W-1:0] d, input logic m);
      exp_t e;
      e.m = m;
      e.e = 1'b0;
      if (m) begin
         e.d = d ^ (d >> 1);
      end else begin
         e.d = ref_g2b(d);
         e.e = m_hist_v && ($countones(d ^ m_hist_d) != 1);
         m_hist_v = 1'b1;
         m_hist_d = d;
      end
      q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic m, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_mode   = m;
      out_ready = r;
      #1;
      if (rst_n && in_valid && in_ready) push_expected(d, m);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      q.delete();
      m_hist_v  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data",  32'(out_data),  32'(0));
      chk("rst_out_mode",  32'(out_mode),  32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(1));
`ifdef GBC_STEP_CHECK_EN
      chk("rst_step_err",  32'(out_step_err), 32'(0));
`endif
   endtask

   // Monitor: pops expected results on output handshakes and checks stall stability.
   initial begin
      logic         stall;
      logic [W-1:0] pd;
      logic         pm;
      exp_t         e;
      stall = 1'b0;
      pd    = '0;
      pm    = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            stall = 1'b0;
            continue;
         end
         if (stall) begin
            chk("bp_hold_valid", 32'(out_valid), 32'(1));
            chk("bp_hold_data",  32'(out_data),  32'(pd));
            chk("bp_hold_mode",  32'(out_mode),  32'(pm));
         end
         if (out_valid && !out_ready) chk("bp_in_ready", 32'(in_ready), 32'(0));
         stall = out_valid && !out_ready;
         pd    = out_data;
         pm    = out_mode;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got data %0h with no word outstanding (t=%0t)", out_data, $time);
            end else begin
               e = q.pop_front();
               chk("sb_data", 32'(out_data), 32'(e.d));
               chk("sb_mode", 32'(out_mode), 32'(e.m));
`ifdef GBC_STEP_CHECK_EN
               chk("sb_step_err", 32'(out_step_err), 32'(e.e));
`endif
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Gray stream, no backpressure, latency and back-to-back results
      drive(1, 4'b0110, 0, 1);
      drive(1, 4'b1011, 0, 1);
      chk("lat_not_early", 32'(out_valid), 32'(0));
      drive(1, 4'b1111, 0, 1);
      chk("lat_valid0", 32'(out_valid), 32'(1));
      chk("lat_data0",  32'(out_data),  32'(4'b0100));
      chk("lat_mode0",  32'(out_mode),  32'(0));
      drive(0, 4'b0000, 0, 1);
      chk("stream_data1", 32'(out_data), 32'(4'b1101));
      drive(0, 4'b0000, 0, 1);
      chk("stream_data2", 32'(out_data), 32'(4'b1010));
      drive(0, 4'b0000, 0, 1);
      chk("bubble_valid", 32'(out_valid), 32'(0));

      // Mixed modes
      drive(1, 4'b1011, 1, 1);
      drive(1, 4'b1110, 0, 1);
      drive(1, 4'b0000, 1, 1);
      chk("mix_data0", 32'(out_data), 32'(4'b1110));
      chk("mix_mode0", 32'(out_mode), 32'(1));
      drive(0, 4'b0000, 0, 1);
      chk("mix_data1", 32'(out_data), 32'(4'b1011));
      drive(0, 4'b0000, 0, 1);
      chk("mix_data2", 32'(out_data), 32'(4'b0000));
      chk("mix_mode2", 32'(out_mode), 32'(1));
      drive(0, 4'b0000, 0, 1);

      // Backpressure for three cycles with a second word queued behind
      drive(1, 4'b0110, 0, 1);
      drive(1, 4'b1011, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 4'b0000, 0, 0);
         chk("bp_valid", 32'(out_valid), 32'(1));
         chk("bp_data",  32'(out_data),  32'(4'b0100));
         chk("bp_ready", 32'(in_ready),  32'(0));
      end
      drive(0, 4'b0000, 0, 1);
      chk("bp_release_data", 32'(out_data), 32'(4'b0100));
      drive(0, 4'b0000, 0, 1);
      chk("bp_next_valid", 32'(out_valid), 32'(1));
      chk("bp_next_data",  32'(out_data),  32'(4'b1101));
      drive(0, 4'b0000, 0, 1);
      chk("bp_no_dup", 32'(out_valid), 32'(0));

      // Reset with two words in flight
      drive(1, 4'b0110, 0, 1);
      drive(1, 4'b1011, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'b0000, 0, 1);
         chk("post_rst_idle", 32'(out_valid), 32'(0));
      end

      // WIDTH=8 instance
      @(negedge clk);
      in_valid8 = 1'b1; in_data8 = 8'b1000_0000; in_mode8 = 1'b0; out_ready8 = 1'b1;
      @(negedge clk);
      in_data8 = 8'b1111_1111; in_mode8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      chk("w8_valid0", 32'(out_valid8), 32'(1));
      chk("w8_g2b",    32'(out_data8),  32'(8'b1111_1111));
      chk("w8_mode0",  32'(out_mode8),  32'(0));
      @(negedge clk);
      #1;
      chk("w8_b2g",    32'(out_data8),  32'(8'b1000_0000));
      chk("w8_mode1",  32'(out_mode8),  32'(1));

      // Gray-step sequence with a binary word interleaved
      do_reset();
      drive(1, 4'b0000, 0, 1);
      drive(1, 4'b0001, 0, 1);
      drive(1, 4'b1111, 1, 1);
      drive(1, 4'b0011, 0, 1);
      drive(1, 4'b0000, 0, 1);
      drive(1, 4'b0000, 0, 1);
      drive(1, 4'b1000, 0, 1);
      drive(1, 4'b0000, 0, 1);
      repeat (3) drive(0, 4'b0000, 0, 1);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 1500; i++) begin
         drive(logic'($urandom_range(0, 3) != 0), W'($urandom), logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 9) < 7));
      end
      repeat (6) drive(0, 4'b0000, 0, 1);
      chk("drain_empty", 32'(q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
